hack_data_bus: RTL and testbench

Data-memory and I/O stage directly downstream of the Hack CPU. It consumes the CPU's addressM/outM/writeM and returns inM in the same cycle. It decodes the 16-bit data address space into:
- general-purpose RAM
- an LED output register
- a synchronised button input
- a memory-mapped UART transmitter with busy status

---
 rtl/hack_data_bus.sv | 89 ++++++++
 tb/tb_hack_data_bus.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/hack_data_bus.sv
// hack_data_bus: Hack data-memory stage decoding RAM, LED, synchronised buttons and a memory-mapped UART TX.
module hack_data_bus #(
  parameter int RAM_WORDS    = 3840,
  parameter int CLKS_PER_BIT = 217,
  parameter int LED_W        = 8,
  parameter int BUT_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addressM,
  input  logic [15:0]       outM,
  input  logic              writeM,
  output logic [15:0]       inM,
  output logic [LED_W-1:0]  led,
  input  logic [BUT_W-1:0]  but,
  output logic              uart_tx
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam logic [15:0] RW = 16'(RAM_WORDS);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [15:0]      ram [RAM_WORDS];
  logic [BUT_W-1:0] but_s1, but_s2;
  state_t           state;
  logic [DW-1:0]    div;
  logic [2:0]       bitcnt;
  logic [7:0]       shift;
  logic             ram_sel, busy, tick, uart_wr;
  assign ram_sel = addressM < RW;
  assign busy    = state != IDLE;
  assign tick    = div == DW'(CLKS_PER_BIT - 1);
  assign uart_wr = writeM && addressM == 16'h4002 && !busy;
  always_comb
    inM = ram_sel                ? ram[addressM[AW-1:0]] :
          addressM == 16'h4000   ? 16'(led) :
          addressM == 16'h4001   ? 16'(but_s2) :
          addressM == 16'h4003   ? {15'h0, busy} : 16'h0000;
  always_ff @(posedge clk)
    if (writeM && ram_sel && !reset) ram[addressM[AW-1:0]] <= outM;
  always_ff @(posedge clk)
    if (reset) begin
      led    <= '0;
      but_s1 <= '0;
      but_s2 <= '0;
    end else begin
      but_s1 <= but;
      but_s2 <= but_s1;
      if (writeM && addressM == 16'h4000) led <= outM[LED_W-1:0];
    end
  // Divider free-runs only while a frame is in flight; tick marks the last cycle of a bit.
  always_ff @(posedge clk)
    if (reset) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      div     <= '0;
      bitcnt  <= '0;
      shift   <= '0;
    end else begin
      if (busy) div <= tick ? '0 : div + 1'b1;
      case (state)
        IDLE:
          if (uart_wr) begin
            shift   <= outM[7:0];
            state   <= START;
            uart_tx <= 1'b0;
          end
        START:
          if (tick) begin
            state   <= DATA;
            uart_tx <= shift[0];
          end
        DATA:
          if (tick) begin
            if (bitcnt == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
              bitcnt  <= '0;
            end else begin
              bitcnt  <= bitcnt + 1'b1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end
        STOP:
          if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hack_data_bus.sv
// tb_hack_data_bus: directed stimulus with a queue-based scoreboard checked by a negedge monitor.
module tb_hack_data_bus;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM, outM, inM;
  logic        writeM;
  logic [7:0]  led;
  logic [3:0]  but;
  logic        uart_tx;
  int          checks = 0, errors = 0;
  typedef struct {
    string       name;
    int          kind;
    logic [15:0] exp;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  hack_data_bus #(.RAM_WORDS(3840), .CLKS_PER_BIT(4), .LED_W(8), .BUT_W(4)) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .led(led), .but(but), .uart_tx(uart_tx)
  );
  // kind 0 = inM, 1 = led, 2 = uart_tx
  task automatic expect_v(input string n, input int k, input logic [15:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = sb.pop_front();
      act = e.kind == 0 ? inM : e.kind == 1 ? {8'h00, led} : {15'h0, uart_tx};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s at %0t: got %h want %h", e.name, $time, act, e.exp);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addressM = a;
    outM     = d;
    writeM   = 1'b1;
    step();
    writeM   = 1'b0;
  endtask
  task automatic rd(input string n, input logic [15:0] a, input logic [15:0] v);
    addressM = a;
    writeM   = 1'b0;
    expect_v(n, 0, v);
    step();
  endtask
  // Expects n cycles of a frame carrying d, starting the cycle after the accepting edge.
  task automatic frame(input logic [7:0] d, input bit noise, input int n);
    for (int i = 0; i < n; i++) begin
      int   j;
      logic b;
      j = i / 4;
      b = j == 0 ? 1'b0 : j == 9 ? 1'b1 : d[j-1];
      if (noise && i == 10) begin
        addressM = 16'h4002;
        outM     = 16'h00FF;
        writeM   = 1'b1;
      end else begin
        addressM = 16'h4003;
        writeM   = 1'b0;
        expect_v("busy_in_frame", 0, 16'h0001);
      end
      expect_v("tx_bit", 2, {15'h0, b});
      step();
    end
    writeM = 1'b0;
  endtask
  initial begin
    reset = 1'b1; writeM = 1'b1; addressM = 16'h4000; outM = 16'h00FF; but = 4'h0;
    step();
    step();
    reset = 1'b0; writeM = 1'b0;
    expect_v("reset_led", 1, 16'h0000);
    expect_v("reset_tx", 2, 16'h0001);
    rd("reset_stat", 16'h4003, 16'h0000);
    wr(16'h0000, 16'h7777);
    wr(16'h0005, 16'h1234);
    wr(16'd3839, 16'hBEEF);
    rd("ram_5", 16'h0005, 16'h1234);
    rd("ram_top", 16'd3839, 16'hBEEF);
    wr(16'h3FFF, 16'h1111);
    wr(16'h8000, 16'h2222);
    rd("unmapped_3fff", 16'h3FFF, 16'h0000);
    rd("unmapped_8000", 16'h8000, 16'h0000);
    rd("ram_0_kept", 16'h0000, 16'h7777);
    rd("ram_5_kept", 16'h0005, 16'h1234);
    rd("uart_data_read", 16'h4002, 16'h0000);
    wr(16'h4000, 16'hABCD);
    expect_v("led_val", 1, 16'h00CD);
    but = 4'b1010;
    rd("led_read", 16'h4000, 16'h00CD);
    rd("but_1edge", 16'h4001, 16'h0000);
    rd("but_2edge", 16'h4001, 16'h000A);
    wr(16'h4001, 16'hFFFF);
    rd("but_wr_ignored", 16'h4001, 16'h000A);
    rd("idle_stat", 16'h4003, 16'h0000);
    wr(16'h4002, 16'h0055);
    frame(8'h55, 1'b1, 40);
    expect_v("first_idle_tx", 2, 16'h0001);
    wr(16'h4002, 16'h00A3);
    frame(8'hA3, 1'b0, 40);
    expect_v("after_a3_tx", 2, 16'h0001);
    rd("after_a3_stat", 16'h4003, 16'h0000);
    wr(16'h4002, 16'h00C3);
    frame(8'hC3, 1'b0, 18);
    reset = 1'b1;
    expect_v("pre_reset_tx", 2, 16'h0000);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_v("post_reset_tx", 2, 16'h0001);
      rd("post_reset_stat", 16'h4003, 16'h0000);
    end
    expect_v("post_reset_led", 1, 16'h0000);
    rd("ram_survives_reset", 16'h0005, 16'h1234);
    wr(16'h4002, 16'h0001);
    frame(8'h01, 1'b0, 40);
    expect_v("final_tx", 2, 16'h0001);
    rd("final_stat", 16'h4003, 16'h0000);
    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
